wb_commit_queue: RTL and testbench
==================================

# wb_commit_queue

Parametrised writeback/commit stage that replaces the single-register WB stage with a DEPTH-entry in-order commit queue between MEM and the register file. It retires one instruction per cycle under trace-port backpressure and resolves exceptions, interrupts and ERET precisely at the queue head. It owns the EPC/BadVAddr/Cause capture registers and provides youngest-first bypass of in-flight results to decode.

## Interface
- DATA_W, 32: result / PC / address width
- DEPTH, 4: queue entries (power of 2, ≥2)
- NUM_INT, 8: interrupt lines
- NO_EX, 5'h1F: ex_code value meaning "no exception"
- INT_CODE, 5'h00: ex_code reported for interrupts

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- ms_valid  in  1  MEM offers an instruction
- ws_allowin  out  1  queue accepts this cycle
- ms_pc, ms_result, ms_badvaddr  in  DATA_W each  payload
- ms_dest  in  5  destination GPR; ms_gr_we in 1 writes GPR
- ms_ex_code  in  5; ms_pc_error, ms_slot, ms_eret  in  1 each
- trace_ready  in  1  trace/debug sink accepts a retire
- rf_we  out  1; rf_waddr out 5; rf_wdata out DATA_W  GPR write
- fwd_raddr  in  5  decode lookup; fwd_hit out 1; fwd_data out DATA_W
- int_pending  in  NUM_INT; int_mask in NUM_INT; int_ie in 1
- ws_flush  out  1  pulse: exception or ERET retiring, flush upstream
- ws_ex  out  1  pulse: exception/interrupt taken
- ws_eret  out  1  pulse: ERET retiring
- ws_target  out  DATA_W  redirect PC (EPC on ERET, 0 on exception)
- cp0_epc, cp0_badvaddr  out  DATA_W; cp0_excode out 5; cp0_bd out 1
- occupancy  out  $clog2(DEPTH)+1  current entry count

## Operation
- Circular buffer: head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, count 0..DEPTH.
- Push: ms_valid && ws_allowin && !ws_flush. ws_allowin = (count < DEPTH) || pop.
- Head commit cycle: count>0 && trace_ready. Head classified:
  - INT: int_ie && |(int_pending & int_mask); overrides entry ex_code.
  - EX: ms_ex_code != NO_EX.
  - ERET: eret flag, no EX/INT.
  - NORMAL otherwise.
- NORMAL: rf_we = gr_we && dest != 0; rf_waddr/rf_wdata from head; pop.
- EX/INT: rf_we=0; ws_ex=ws_flush=1; next edge: cp0_epc ← slot ? pc−4 : pc; cp0_bd ← slot; cp0_excode ← code; cp0_badvaddr ← pc_error ? badvaddr : unchanged; entire queue cleared (count=0, head=tail).
- ERET: rf_we=0; ws_eret=ws_flush=1; ws_target=cp0_epc; queue cleared next edge.
- Push in a flush cycle is dropped.
- Simultaneous push and NORMAL pop: count unchanged, both pointers advance.
- Bypass: fwd_hit=1 when some valid entry has gr_we && dest==fwd_raddr && fwd_raddr!=0 and no EX code; fwd_data from youngest such entry (nearest to tail). Combinational.
- No commit while count=0 or trace_ready=0; interrupt is only sampled at a committable head.

## Timing
- Reset values: count=0, head=tail=0, cp0_epc=cp0_badvaddr=0, cp0_excode=NO_EX, cp0_bd=0; all pulses, rf_we, fwd_hit=0; ws_allowin=1.
- Latency: entry pushed at edge N is committable in cycle N+1 (earliest rf_we one cycle after acceptance).
- rf_we, ws_flush, ws_ex, ws_eret: combinational, single-cycle, asserted only in commit cycle.
- CP0 capture registers update on the edge ending the EX/INT cycle; visible next cycle.
- Full (count=DEPTH) with trace_ready=0: ws_allowin=0. With trace_ready=1 and NORMAL head: ws_allowin=1.
- Reset mid-operation discards all entries; no rf_we in the reset cycle.

## Test plan
- Push 4 NORMAL writes (dest 1..4, data 0x11..0x44), trace_ready=1 -> rf_we on 4 consecutive cycles in order, occupancy peaks at 1.
- trace_ready=0, push 5 -> 4 accepted, ws_allowin=0 on 5th; release -> in-order drain, 5th accepted in first pop cycle.
- Queue holds dest 5 = 0xA then dest 5 = 0xB, fwd_raddr=5 -> fwd_hit=1, fwd_data=0xB; fwd_raddr=0 -> hit=0.
- Head ex_code=4, pc_error=1, badvaddr=0x8000_0003, slot=1, pc=0xBFC0_0104, two younger entries -> ws_ex=1, rf_we=0; next cycle cp0_epc=0xBFC0_0100, cp0_bd=1, badvaddr captured, occupancy=0.
- int_ie=1, int_pending=0x04, int_mask=0x04 with NORMAL head -> taken as INT, cp0_excode=0, no rf_we; mask=0 -> normal retire.
- cp0_epc=0x1000, ERET at head plus concurrent push -> ws_eret=1, ws_target=0x1000, push dropped, occupancy=0 next cycle.

Source files
------------

// File: rtl/wb_commit_queue.sv
// wb_commit_queue: in-order commit queue for writeback that handles exceptions, interrupts and ERET precisely at the head.
module wb_commit_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter int NUM_INT = 8,
  parameter logic [4:0] NO_EX = 5'h1F,
  parameter logic [4:0] INT_CODE = 5'h00
) (
  input  logic clk,
  input  logic reset,
  input  logic ms_valid,
  output logic ws_allowin,
  input  logic [DATA_W-1:0] ms_pc,
  input  logic [DATA_W-1:0] ms_result,
  input  logic [DATA_W-1:0] ms_badvaddr,
  input  logic [4:0] ms_dest,
  input  logic ms_gr_we,
  input  logic [4:0] ms_ex_code,
  input  logic ms_pc_error,
  input  logic ms_slot,
  input  logic ms_eret,
  input  logic trace_ready,
  output logic rf_we,
  output logic [4:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [4:0] fwd_raddr,
  output logic fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  input  logic [NUM_INT-1:0] int_pending,
  input  logic [NUM_INT-1:0] int_mask,
  input  logic int_ie,
  output logic ws_flush,
  output logic ws_ex,
  output logic ws_eret,
  output logic [DATA_W-1:0] ws_target,
  output logic [DATA_W-1:0] cp0_epc,
  output logic [DATA_W-1:0] cp0_badvaddr,
  output logic [4:0] cp0_excode,
  output logic cp0_bd,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [DATA_W-1:0] q_pc [DEPTH];
  logic [DATA_W-1:0] q_res [DEPTH];
  logic [DATA_W-1:0] q_bva [DEPTH];
  logic [4:0] q_dest [DEPTH];
  logic [4:0] q_ex [DEPTH];
  logic q_we [DEPTH];
  logic q_pe [DEPTH];
  logic q_slot [DEPTH];
  logic q_eret [DEPTH];
  logic [AW-1:0] age_idx [DEPTH];
  logic can_commit, int_take, hd_ex, is_int, is_ex, is_eret, pop, push;
  assign can_commit = !reset && count != '0 && trace_ready;
  assign int_take = int_ie && |(int_pending & int_mask);
  assign hd_ex = q_ex[head] != NO_EX;
  assign is_int = can_commit && int_take;
  assign is_ex = can_commit && !int_take && hd_ex;
  assign is_eret = can_commit && !int_take && !hd_ex && q_eret[head];
  assign pop = can_commit && !int_take && !hd_ex && !q_eret[head];
  assign ws_ex = is_int || is_ex;
  assign ws_eret = is_eret;
  assign ws_flush = ws_ex || is_eret;
  assign ws_target = is_eret ? cp0_epc : '0;
  assign ws_allowin = count < CW'(DEPTH) || pop;
  assign push = ms_valid && ws_allowin && !ws_flush;
  assign rf_we = pop && q_we[head] && q_dest[head] != 5'd0;
  assign rf_waddr = q_dest[head];
  assign rf_wdata = q_res[head];
  assign occupancy = count;
  for (genvar j = 0; j < DEPTH; j++) begin : g_age
    assign age_idx[j] = head + AW'(j);
  end
  // Scan oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count && q_we[age_idx[i]] && q_dest[age_idx[i]] == fwd_raddr &&
          fwd_raddr != 5'd0 && q_ex[age_idx[i]] == NO_EX) begin
        fwd_hit = 1'b1;
        fwd_data = q_res[age_idx[i]];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      cp0_epc <= '0;
      cp0_badvaddr <= '0;
      cp0_excode <= NO_EX;
      cp0_bd <= 1'b0;
    end else if (ws_flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      if (ws_ex) begin
        cp0_epc <= q_slot[head] ? q_pc[head] - DATA_W'(4) : q_pc[head];
        cp0_bd <= q_slot[head];
        cp0_excode <= is_int ? INT_CODE : q_ex[head];
        if (q_pe[head]) cp0_badvaddr <= q_bva[head];
      end
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail] <= ms_pc;
      q_res[tail] <= ms_result;
      q_bva[tail] <= ms_badvaddr;
      q_dest[tail] <= ms_dest;
      q_ex[tail] <= ms_ex_code;
      q_we[tail] <= ms_gr_we;
      q_pe[tail] <= ms_pc_error;
      q_slot[tail] <= ms_slot;
      q_eret[tail] <= ms_eret;
    end
  end
endmodule

// File: tb/tb_wb_commit_queue.sv
// tb_wb_commit_queue: scoreboard bench; expected retire events are queued at issue and checked by a monitor.
module tb_wb_commit_queue;
  localparam logic [4:0] NO_EX = 5'h1F;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ms_valid = 1'b0;
  logic ws_allowin;
  logic [31:0] ms_pc = '0, ms_result = '0, ms_badvaddr = '0;
  logic [4:0] ms_dest = '0, ms_ex_code = NO_EX;
  logic ms_gr_we = 1'b0, ms_pc_error = 1'b0, ms_slot = 1'b0, ms_eret = 1'b0;
  logic trace_ready = 1'b0;
  logic rf_we;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0] fwd_raddr = '0;
  logic fwd_hit;
  logic [31:0] fwd_data;
  logic [7:0] int_pending = '0, int_mask = '0;
  logic int_ie = 1'b0;
  logic ws_flush, ws_ex, ws_eret;
  logic [31:0] ws_target, cp0_epc, cp0_badvaddr;
  logic [4:0] cp0_excode;
  logic cp0_bd;
  logic [2:0] occupancy;
  int total = 0;
  int bad = 0;
  typedef struct packed {logic [1:0] k; logic [4:0] a; logic [31:0] d;} ev_t;
  ev_t exp_q[$];
  ev_t mon_a, mon_e;

  wb_commit_queue dut (
    .clk(clk), .reset(reset), .ms_valid(ms_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_result(ms_result), .ms_badvaddr(ms_badvaddr),
    .ms_dest(ms_dest), .ms_gr_we(ms_gr_we), .ms_ex_code(ms_ex_code),
    .ms_pc_error(ms_pc_error), .ms_slot(ms_slot), .ms_eret(ms_eret),
    .trace_ready(trace_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_raddr(fwd_raddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .int_pending(int_pending), .int_mask(int_mask), .int_ie(int_ie),
    .ws_flush(ws_flush), .ws_ex(ws_ex), .ws_eret(ws_eret), .ws_target(ws_target),
    .cp0_epc(cp0_epc), .cp0_badvaddr(cp0_badvaddr), .cp0_excode(cp0_excode),
    .cp0_bd(cp0_bd), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, expv);
    end
  endtask

  // Event kinds: 0 = register write, 1 = exception/interrupt, 2 = ERET.
  always @(negedge clk) begin
    if (rf_we || ws_flush) begin
      mon_a.k = rf_we ? 2'd0 : (ws_ex ? 2'd1 : 2'd2);
      mon_a.a = rf_we ? rf_waddr : 5'd0;
      mon_a.d = rf_we ? rf_wdata : ws_target;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_retire: got %0h expected none", mon_a);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          bad++;
          $display("FAIL retire: got %0h expected %0h", mon_a, mon_e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] d, input logic [31:0] r, input logic we, input logic [4:0] ex,
                       input logic pe, input logic sl, input logic er, input logic [31:0] pc, input logic [31:0] bva);
    ms_valid = 1'b1;
    ms_dest = d;
    ms_result = r;
    ms_gr_we = we;
    ms_ex_code = ex;
    ms_pc_error = pe;
    ms_slot = sl;
    ms_eret = er;
    ms_pc = pc;
    ms_badvaddr = bva;
  endtask

  task automatic exp_ev(input logic [1:0] k, input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({k, a, d});
  endtask

  initial begin
    step();
    step();
    @(negedge clk);
    chk("rst_occ", occupancy, 0);
    chk("rst_allowin", ws_allowin, 1);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_excode", cp0_excode, 5'h1F);
    chk("rst_epc", cp0_epc, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    reset = 1'b0;
    step();
    // streaming retire
    trace_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(5'(i), 32'(i * 17), 1'b1, NO_EX, 1'b0, 1'b0, 1'b0, 32'h100 + 32'(i * 4), '0);
      exp_ev(2'd0, 5'(i), 32'(i * 17));
      @(negedge clk);
      chk("t1_allowin", ws_allowin, 1);
      chk("t1_occ", occupancy, (i == 1) ? 0 : 1);
      step();
    end
    ms_valid = 1'b0;
    @(negedge clk);
    chk("t1_occ_tail", occupancy, 1);
    step();
    @(negedge clk);
    chk("t1_occ_empty", occupancy, 0);
    step();
    // fill under backpressure
    trace_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(5'(6 + i), 32'h60 + 32'(i), 1'b1, NO_EX, 1'b0, 1'b0, 1'b0, 32'h200, '0);
      exp_ev(2'd0, 5'(6 + i), 32'h60 + 32'(i));
      step();
    end
    drive(5'd10, 32'h64, 1'b1, NO_EX, 1'b0, 1'b0, 1'b0, 32'h210, '0);
    @(negedge clk);
    chk("t2_full_allowin", ws_allowin, 0);
    chk("t2_full_occ", occupancy, 4);
    step();
    trace_ready = 1'b1;
    exp_ev(2'd0, 5'd10, 32'h64);
    @(negedge clk);
    chk("t2_pop_allowin", ws_allowin, 1);
    step();
    ms_valid = 1'b0;
    @(negedge clk);
    chk("t2_occ_after", occupancy, 4);
    repeat (4) step();
    @(negedge clk);
    chk("t2_drained", occupancy, 0);
    step();
    // youngest-first bypass
    trace_ready = 1'b0;
    drive(5'd5, 32'hA, 1'b1, NO_EX, 1'b0, 1'b0, 1'b0, 32'h300, '0);
    exp_ev(2'd0, 5'd5, 32'hA);
    step();
    drive(5'd5, 32'hB, 1'b1, NO_EX, 1'b0, 1'b0, 1'b0, 32'h304, '0);
    exp_ev(2'd0, 5'd5, 32'hB);
    step();
    ms_valid = 1'b0;
    fwd_raddr = 5'd5;
    @(negedge clk);
    chk("t3_hit", fwd_hit, 1);
    chk("t3_data", fwd_data, 32'hB);
    fwd_raddr = 5'd0;
    #1;
    chk("t3_r0_hit", fwd_hit, 0);
    fwd_raddr = 5'd7;
    #1;
    chk("t3_miss", fwd_hit, 0);
    step();
    trace_ready = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("t3_drained", occupancy, 0);
    step();
    // exception at head with two younger entries
    trace_ready = 1'b0;
    drive(5'd3, 32'h33, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 32'hBFC0_0104, 32'h8000_0003);
    step();
    drive(5'd8, 32'h88, 1'b1, NO_EX, 1'b0, 1'b0, 1'b0, 32'hBFC0_0108, '0);
    step();
    drive(5'd9, 32'h99, 1'b1, NO_EX, 1'b0, 1'b0, 1'b0, 32'hBFC0_010C, '0);
    step();
    ms_valid = 1'b0;
    fwd_raddr = 5'd3;
    @(negedge clk);
    chk("t4_ex_no_fwd", fwd_hit, 0);
    fwd_raddr = 5'd9;
    #1;
    chk("t4_fwd9_hit", fwd_hit, 1);
    chk("t4_fwd9_data", fwd_data, 32'h99);
    chk("t4_occ", occupancy, 3);
    step();
    trace_ready = 1'b1;
    exp_ev(2'd1, 5'd0, 32'd0);
    @(negedge clk);
    chk("t4_rf_we", rf_we, 0);
    chk("t4_ws_ex", ws_ex, 1);
    step();
    @(negedge clk);
    chk("t4_epc", cp0_epc, 32'hBFC0_0100);
    chk("t4_bd", cp0_bd, 1);
    chk("t4_bva", cp0_badvaddr, 32'h8000_0003);
    chk("t4_excode", cp0_excode, 4);
    chk("t4_occ", occupancy, 0);
    step();
    // interrupt overrides a normal head
    trace_ready = 1'b0;
    int_ie = 1'b1;
    int_pending = 8'h04;
    int_mask = 8'h04;
    drive(5'd12, 32'hC0, 1'b1, NO_EX, 1'b0, 1'b0, 1'b0, 32'h2000, '0);
    step();
    ms_valid = 1'b0;
    trace_ready = 1'b1;
    exp_ev(2'd1, 5'd0, 32'd0);
    @(negedge clk);
    chk("t5_rf_we", rf_we, 0);
    step();
    @(negedge clk);
    chk("t5_excode", cp0_excode, 0);
    chk("t5_epc", cp0_epc, 32'h2000);
    chk("t5_bd", cp0_bd, 0);
    chk("t5_bva_kept", cp0_badvaddr, 32'h8000_0003);
    chk("t5_occ", occupancy, 0);
    step();
    int_mask = 8'h00;
    drive(5'd12, 32'hC1, 1'b1, NO_EX, 1'b0, 1'b0, 1'b0, 32'h2004, '0);
    exp_ev(2'd0, 5'd12, 32'hC1);
    step();
    ms_valid = 1'b0;
    @(negedge clk);
    chk("t5_masked_occ", occupancy, 1);
    step();
    @(negedge clk);
    chk("t5_masked_done", occupancy, 0);
    step();
    // set EPC to 0x1000 via a syscall-style exception, then ERET
    int_ie = 1'b0;
    trace_ready = 1'b0;
    drive(5'd0, 32'd0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 32'h1000, '0);
    step();
    ms_valid = 1'b0;
    trace_ready = 1'b1;
    exp_ev(2'd1, 5'd0, 32'd0);
    step();
    @(negedge clk);
    chk("t6_epc_set", cp0_epc, 32'h1000);
    chk("t6_excode8", cp0_excode, 8);
    step();
    trace_ready = 1'b0;
    drive(5'd0, 32'd0, 1'b0, NO_EX, 1'b0, 1'b0, 1'b1, 32'h3000, '0);
    step();
    drive(5'd13, 32'hD0, 1'b1, NO_EX, 1'b0, 1'b0, 1'b0, 32'h3004, '0);
    trace_ready = 1'b1;
    exp_ev(2'd2, 5'd0, 32'h1000);
    @(negedge clk);
    chk("t6_eret", ws_eret, 1);
    chk("t6_target", ws_target, 32'h1000);
    chk("t6_flush", ws_flush, 1);
    step();
    ms_valid = 1'b0;
    @(negedge clk);
    chk("t6_occ", occupancy, 0);
    chk("t6_epc_kept", cp0_epc, 32'h1000);
    repeat (2) step();
    // reset mid-operation
    trace_ready = 1'b0;
    drive(5'd14, 32'hE0, 1'b1, NO_EX, 1'b0, 1'b0, 1'b0, 32'h4000, '0);
    step();
    drive(5'd15, 32'hF0, 1'b1, NO_EX, 1'b0, 1'b0, 1'b0, 32'h4004, '0);
    step();
    ms_valid = 1'b0;
    reset = 1'b1;
    trace_ready = 1'b1;
    @(negedge clk);
    chk("t7_rf_we", rf_we, 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t7_occ", occupancy, 0);
    chk("t7_epc", cp0_epc, 0);
    chk("t7_excode", cp0_excode, 5'h1F);
    chk("t7_allowin", ws_allowin, 1);
    repeat (2) step();
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
